video_timing_detect: RTL and testbench
======================================

VIDEO_TIMING_DETECT -- requirements
Module: video_timing_detect

Interface
REQ-001 SHALL have parameter CNT_W, default 12: width of all pixel, line and measurement counters.
REQ-002 SHALL have parameter LOCK_FRAMES, default 2: number of consecutive matching frames required for lock (range 1..15).
REQ-003 SHALL have parameter HS_POL, default 1: active level of I_HSYNC; SHALL have parameter VS_POL, default 1: active level of I_VSYNC.
REQ-004 SHALL have ports, clock and reset first:
  I_PCLK       in   1      pixel clock; the only clock
  I_RST        in   1      reset, asynchronous, active-high
  I_PIX_DATA   in   24     RGB pixel
  I_HSYNC      in   1      horizontal sync
  I_VSYNC      in   1      vertical sync
  I_DE         in   1      data enable
  O_PIX_DATA   out  24     I_PIX_DATA delayed 1 cycle
  O_DE         out  1      I_DE delayed 1 cycle
  O_HSYNC      out  1      I_HSYNC delayed 1 cycle
  O_VSYNC      out  1      I_VSYNC delayed 1 cycle
  O_PIX_COL    out  CNT_W  column of O_PIX_DATA
  O_PIX_ROW    out  CNT_W  row of O_PIX_DATA
  O_SOF        out  1      pulse with first active pixel of a frame
  O_H_ACT      out  CNT_W  reference active pixels per line
  O_V_ACT      out  CNT_W  reference active lines per frame
  O_LOCKED     out  1      timing locked

Function
REQ-005 SHALL register I_PIX_DATA, I_DE, I_HSYNC, I_VSYNC once; all outputs SHALL be aligned to this 1-cycle latency.
REQ-006 Column counter SHALL load 0 on a cycle where I_DE is high and was low the previous cycle, increment each further I_DE-high cycle, and saturate at 2^CNT_W-1 with a sticky overflow flag for the frame.
REQ-007 Row counter SHALL increment on each I_DE falling edge and SHALL clear on frame boundary; it SHALL saturate like the column counter.
REQ-008 Frame boundary SHALL be the cycle I_VSYNC transitions to its active level (VS_POL); I_HSYNC is passed through only and not used for measurement.
REQ-009 On each I_DE falling edge the line width (final column+1) SHALL be compared with the frame's first line width; any difference SHALL set a sticky frame-inconsistent flag.
REQ-010 A frame SHALL be consistent iff at the boundary: rows>0, no overflow, no inconsistent flag.
REQ-011 O_SOF SHALL be high for exactly one cycle with the first O_DE-high pixel after a boundary (row 0, col 0).
REQ-012 If a boundary and an I_DE rising edge coincide, the boundary SHALL be processed first and that line SHALL be row 0.
REQ-013 Lock FSM states UNLOCKED, ACQUIRE, LOCKED, evaluated at each boundary:
  UNLOCKED: consistent -> ACQUIRE, match count=1, load O_H_ACT/O_V_ACT with measured values; else stay.
  ACQUIRE: consistent and equal to O_H_ACT/O_V_ACT -> count+1, -> LOCKED when count reaches LOCK_FRAMES; consistent but different -> reload reference, count=1; inconsistent -> UNLOCKED.
  LOCKED: inconsistent or different -> UNLOCKED.
REQ-014 In LOCKED, a line width differing from O_H_ACT, or a row count exceeding O_V_ACT, SHALL force UNLOCKED on the next cycle without waiting for the boundary.
REQ-015 O_LOCKED SHALL be high iff state is LOCKED; O_H_ACT/O_V_ACT SHALL hold their last values in UNLOCKED.
REQ-016 With LOCK_FRAMES=1, a first consistent frame SHALL go UNLOCKED -> LOCKED directly.

Reset
REQ-017 I_RST SHALL asynchronously clear all registers; during and after reset every output SHALL be 0 and state SHALL be UNLOCKED.
REQ-018 Reset mid-frame SHALL discard partial measurements; the first boundary after reset SHALL start a fresh measurement and SHALL NOT be evaluated.

Configuration
REQ-019 Macro VIDEO_TIMING_DETECT_ERR_CNT_EN defined: SHALL add output O_ERR_CNT [7:0], reset 0, incrementing (saturating at 255) on every LOCKED -> UNLOCKED transition.
REQ-020 Macro undefined: O_ERR_CNT and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-021 Three 8x4 frames, LOCK_FRAMES=2 -> O_LOCKED rises 1 cycle after third VSYNC assertion; O_H_ACT=8, O_V_ACT=4.
REQ-022 Locked 8x4, then one line 7 pixels -> O_LOCKED low 1 cycle after that DE falls; O_ERR_CNT=1 when macro defined.
REQ-023 640x480 standard VGA timing, three frames -> O_H_ACT=640, O_V_ACT=480, O_LOCKED=1; O_SOF with O_PIX_ROW=0, O_PIX_COL=0.
REQ-024 Alternating 8x4 and 8x5 frames -> O_LOCKED stays 0; O_V_ACT tracks latest frame.
REQ-025 I_RST pulsed mid-frame while locked -> all outputs 0 immediately; relock after 3 more boundaries.
REQ-026 VSYNC active edge coincident with DE rise -> that line reports O_PIX_ROW=0, O_SOF=1.

Source files
------------

// File: rtl/video_timing_detect.sv
// Video timing detector: measures active width/height from DE/VSYNC and locks after
// LOCK_FRAMES matching frames. Optional O_ERR_CNT under VIDEO_TIMING_DETECT_ERR_CNT_EN.
module video_timing_detect #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 1
) (
  input  logic             I_PCLK,
  input  logic             I_RST,
  input  logic [23:0]      I_PIX_DATA,
  input  logic             I_HSYNC,
  input  logic             I_VSYNC,
  input  logic             I_DE,
  output logic [23:0]      O_PIX_DATA,
  output logic             O_DE,
  output logic             O_HSYNC,
  output logic             O_VSYNC,
  output logic [CNT_W-1:0] O_PIX_COL,
  output logic [CNT_W-1:0] O_PIX_ROW,
  output logic             O_SOF,
  output logic [CNT_W-1:0] O_H_ACT,
  output logic [CNT_W-1:0] O_V_ACT,
  output logic             O_LOCKED
`ifdef VIDEO_TIMING_DETECT_ERR_CNT_EN
  ,
  output logic [7:0]       O_ERR_CNT
`endif
);

  typedef enum logic [1:0] {UNLOCKED = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic             VS_ACT  = VS_POL[0];
  localparam logic [4:0]       LOCK_N  = 5'(LOCK_FRAMES);

  // HSYNC is a pure passthrough, so its polarity never enters the logic.
  logic unused_hs_pol;
  assign unused_hs_pol = HS_POL[0];

  logic [23:0]      pix_q;
  logic             de_q, hs_q, vs_q;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic             sof_q, sof_d, sof_pend_q, sof_pend_d;
  logic             ovf_q, ovf_d, inc_q, inc_d, armed_q, armed_d;
  logic             first_done_q, first_done_d;
  logic [CNT_W-1:0] first_w_q, first_w_d;
  logic [CNT_W-1:0] h_act_q, h_act_d, v_act_q, v_act_d;
  logic [3:0]       match_q, match_d;
  state_t           state_q, state_d;

  logic             boundary, de_rise, de_fall, col_max, col_ovf, row_ovf, w_ovf;
  logic             line_bad, consistent, eval, same, live_bad;
  logic [CNT_W-1:0] line_w;
  logic [4:0]       match_inc;

  always_comb begin
    boundary = (I_VSYNC == VS_ACT) && (vs_q != VS_ACT);
    de_rise  = I_DE && !de_q;
    de_fall  = !I_DE && de_q;
    col_max  = (col_q == CNT_MAX);
    line_w   = col_q + CNT_W'(1);
    // A line of exactly 2^CNT_W pixels has an unrepresentable width.
    w_ovf    = de_fall && col_max;

    col_d   = col_q;
    col_ovf = 1'b0;
    if (de_rise)      col_d = '0;
    else if (I_DE) begin
      if (col_max)    col_ovf = 1'b1;
      else            col_d   = col_q + CNT_W'(1);
    end

    row_d   = row_q;
    row_ovf = 1'b0;
    if (boundary)     row_d = '0;
    else if (de_fall) begin
      if (row_q == CNT_MAX) row_ovf = 1'b1;
      else                  row_d   = row_q + CNT_W'(1);
    end

    line_bad     = de_fall && first_done_q && (line_w != first_w_q);
    first_done_d = first_done_q;
    first_w_d    = first_w_q;
    if (boundary) first_done_d = 1'b0;
    else if (de_fall && !first_done_q) begin
      first_done_d = 1'b1;
      first_w_d    = line_w;
    end

    ovf_d   = boundary ? 1'b0 : (ovf_q | col_ovf | row_ovf | w_ovf);
    inc_d   = boundary ? 1'b0 : (inc_q | line_bad);
    armed_d = armed_q | boundary;

    // Boundary wins over a coincident DE rise, so that line becomes row 0.
    sof_d      = I_DE && (boundary || sof_pend_q);
    sof_pend_d = boundary ? !I_DE : (sof_pend_q && !I_DE);
  end

  // Lock FSM: evaluated at armed boundaries, plus a mid-frame watchdog in LOCKED.
  always_comb begin
    consistent = (row_q != '0) && !ovf_q && !inc_q;
    eval       = boundary && armed_q;
    same       = (first_w_q == h_act_q) && (row_q == v_act_q);
    live_bad   = (line_w != h_act_q) || w_ovf || (row_q >= v_act_q);
    match_inc  = {1'b0, match_q} + 5'd1;

    state_d = state_q;
    match_d = match_q;
    h_act_d = h_act_q;
    v_act_d = v_act_q;
    case (state_q)
      UNLOCKED: begin
        if (eval && consistent) begin
          h_act_d = first_w_q;
          v_act_d = row_q;
          match_d = 4'd1;
          state_d = (LOCK_N <= 5'd1) ? LOCKED : ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (eval) begin
          if (!consistent) begin
            state_d = UNLOCKED;
            match_d = 4'd0;
          end else if (same) begin
            match_d = match_inc[3:0];
            if (match_inc >= LOCK_N) state_d = LOCKED;
          end else begin
            h_act_d = first_w_q;
            v_act_d = row_q;
            match_d = 4'd1;
          end
        end
      end
      LOCKED: begin
        if (eval) begin
          if (!consistent || !same) begin
            state_d = UNLOCKED;
            match_d = 4'd0;
          end
        end else if (de_fall && live_bad) begin
          state_d = UNLOCKED;
          match_d = 4'd0;
        end
      end
      default: begin
        state_d = UNLOCKED;
        match_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge I_PCLK or posedge I_RST) begin
    if (I_RST) begin
      pix_q        <= '0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      sof_q        <= 1'b0;
      sof_pend_q   <= 1'b0;
      ovf_q        <= 1'b0;
      inc_q        <= 1'b0;
      armed_q      <= 1'b0;
      first_done_q <= 1'b0;
      first_w_q    <= '0;
      h_act_q      <= '0;
      v_act_q      <= '0;
      match_q      <= '0;
      state_q      <= UNLOCKED;
    end else begin
      pix_q        <= I_PIX_DATA;
      de_q         <= I_DE;
      hs_q         <= I_HSYNC;
      vs_q         <= I_VSYNC;
      col_q        <= col_d;
      row_q        <= row_d;
      sof_q        <= sof_d;
      sof_pend_q   <= sof_pend_d;
      ovf_q        <= ovf_d;
      inc_q        <= inc_d;
      armed_q      <= armed_d;
      first_done_q <= first_done_d;
      first_w_q    <= first_w_d;
      h_act_q      <= h_act_d;
      v_act_q      <= v_act_d;
      match_q      <= match_d;
      state_q      <= state_d;
    end
  end

`ifdef VIDEO_TIMING_DETECT_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == LOCKED && state_d == UNLOCKED && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge I_PCLK or posedge I_RST) begin
    if (I_RST) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign O_ERR_CNT = err_cnt_q;
`endif

  assign O_PIX_DATA = pix_q;
  assign O_DE       = de_q;
  assign O_HSYNC    = hs_q;
  assign O_VSYNC    = vs_q;
  assign O_PIX_COL  = col_q;
  assign O_PIX_ROW  = row_q;
  assign O_SOF      = sof_q;
  assign O_H_ACT    = h_act_q;
  assign O_V_ACT    = v_act_q;
  assign O_LOCKED   = (state_q == LOCKED);

endmodule

// File: tb/tb_video_timing_detect.sv
// Directed bench for video_timing_detect: lock acquisition, unlock, reset, SOF alignment.
module tb_video_timing_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] I_PIX_DATA;
  logic        I_HSYNC, I_VSYNC, I_DE;
  logic [23:0] O_PIX_DATA, o1_pix;
  logic        O_DE, O_HSYNC, O_VSYNC, O_SOF, O_LOCKED;
  logic        o1_de, o1_hs, o1_vs, o1_sof, o1_locked;
  logic [11:0] O_PIX_COL, O_PIX_ROW, O_H_ACT, O_V_ACT;
  logic [11:0] o1_col, o1_row, o1_h, o1_v;
`ifdef VIDEO_TIMING_DETECT_ERR_CNT_EN
  logic [7:0]  O_ERR_CNT, o1_err;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  video_timing_detect #(.CNT_W(12), .LOCK_FRAMES(2)) u_dut (
    .I_PCLK(clk), .I_RST(rst), .I_PIX_DATA(I_PIX_DATA), .I_HSYNC(I_HSYNC),
    .I_VSYNC(I_VSYNC), .I_DE(I_DE), .O_PIX_DATA(O_PIX_DATA), .O_DE(O_DE),
    .O_HSYNC(O_HSYNC), .O_VSYNC(O_VSYNC), .O_PIX_COL(O_PIX_COL), .O_PIX_ROW(O_PIX_ROW),
    .O_SOF(O_SOF), .O_H_ACT(O_H_ACT), .O_V_ACT(O_V_ACT), .O_LOCKED(O_LOCKED)
`ifdef VIDEO_TIMING_DETECT_ERR_CNT_EN
    , .O_ERR_CNT(O_ERR_CNT)
`endif
  );

  // Second instance shares the stimulus to cover single-frame lock.
  video_timing_detect #(.CNT_W(12), .LOCK_FRAMES(1)) u_dut1 (
    .I_PCLK(clk), .I_RST(rst), .I_PIX_DATA(I_PIX_DATA), .I_HSYNC(I_HSYNC),
    .I_VSYNC(I_VSYNC), .I_DE(I_DE), .O_PIX_DATA(o1_pix), .O_DE(o1_de),
    .O_HSYNC(o1_hs), .O_VSYNC(o1_vs), .O_PIX_COL(o1_col), .O_PIX_ROW(o1_row),
    .O_SOF(o1_sof), .O_H_ACT(o1_h), .O_V_ACT(o1_v), .O_LOCKED(o1_locked)
`ifdef VIDEO_TIMING_DETECT_ERR_CNT_EN
    , .O_ERR_CNT(o1_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pix(input int r, input int c);
    return 24'h5A0000 | 24'((r & 15) << 12) | 24'(c & 12'hFFF);
  endfunction

  // Raise VSYNC for one cycle; caller checks the boundary result afterwards.
  task automatic vs_start();
    I_VSYNC = 1'b1;
    I_DE    = 1'b0;
    tick();
  endtask

  task automatic line(input int r, input int w);
    for (int c = 0; c < w; c++) begin
      I_DE       = 1'b1;
      I_PIX_DATA = pix(r, c);
      tick();
      if (c == 0) begin
        chk("sof", 32'(O_SOF), 32'(r == 0));
        chk("row_first", 32'(O_PIX_ROW), 32'(r));
        chk("col_first", 32'(O_PIX_COL), 32'd0);
        chk("pix_data", 32'(O_PIX_DATA), 32'(pix(r, 0)));
      end
      if (c == w - 1 && w > 1) chk("col_last", 32'(O_PIX_COL), 32'((c > 4095) ? 4095 : c));
    end
    I_DE = 1'b0;
    tick();
  endtask

  task automatic gap(input int r);
    I_HSYNC = 1'b1;
    tick();
    if (r == 0) chk("hsync_pass", 32'(O_HSYNC), 32'd1);
    I_HSYNC = 1'b0;
    tick();
  endtask

  task automatic body(input int h, input int v);
    tick();
    I_VSYNC = 1'b0;
    tick();
    tick();
    for (int r = 0; r < v; r++) begin
      line(r, h);
      gap(r);
    end
  endtask

  initial begin
    rst        = 1'b1;
    I_PIX_DATA = 24'hFFFFFF;
    I_HSYNC    = 1'b1;
    I_VSYNC    = 1'b1;
    I_DE       = 1'b1;
    tick();
    tick();
    chk("rst_pix", 32'(O_PIX_DATA), 32'd0);
    chk("rst_de", 32'(O_DE), 32'd0);
    chk("rst_hs", 32'(O_HSYNC), 32'd0);
    chk("rst_vs", 32'(O_VSYNC), 32'd0);
    chk("rst_col", 32'(O_PIX_COL), 32'd0);
    chk("rst_row", 32'(O_PIX_ROW), 32'd0);
    chk("rst_sof", 32'(O_SOF), 32'd0);
    chk("rst_hact", 32'(O_H_ACT), 32'd0);
    chk("rst_vact", 32'(O_V_ACT), 32'd0);
    chk("rst_lock", 32'(O_LOCKED), 32'd0);
    I_PIX_DATA = '0;
    I_HSYNC    = 1'b0;
    I_VSYNC    = 1'b0;
    I_DE       = 1'b0;
    rst        = 1'b0;
    tick();

    // Three 8x4 frames: arm, acquire, lock.
    vs_start();
    chk("vs_pass", 32'(O_VSYNC), 32'd1);
    chk("b1_lock", 32'(O_LOCKED), 32'd0);
    chk("b1_hact", 32'(O_H_ACT), 32'd0);
    body(8, 4);
    vs_start();
    chk("b2_lock", 32'(O_LOCKED), 32'd0);
    chk("b2_hact", 32'(O_H_ACT), 32'd8);
    chk("b2_vact", 32'(O_V_ACT), 32'd4);
    chk("lf1_lock", 32'(o1_locked), 32'd1);
    body(8, 4);
    vs_start();
    chk("b3_lock", 32'(O_LOCKED), 32'd1);
    chk("b3_hact", 32'(O_H_ACT), 32'd8);
    chk("b3_vact", 32'(O_V_ACT), 32'd4);
    body(8, 4);
    vs_start();
    chk("b4_lock", 32'(O_LOCKED), 32'd1);

    // Short line while locked drops lock right after its DE fall.
    tick();
    I_VSYNC = 1'b0;
    tick();
    tick();
    line(0, 8);
    gap(0);
    chk("pre_short_lock", 32'(O_LOCKED), 32'd1);
    line(1, 7);
    chk("short_unlock", 32'(O_LOCKED), 32'd0);
`ifdef VIDEO_TIMING_DETECT_ERR_CNT_EN
    chk("err_cnt", 32'(O_ERR_CNT), 32'd1);
`endif
    gap(1);
    line(2, 8);
    gap(2);
    line(3, 8);
    gap(3);
    vs_start();
    chk("bad_frame_lock", 32'(O_LOCKED), 32'd0);
    chk("bad_frame_vact", 32'(O_V_ACT), 32'd4);

    // Alternating heights never lock; reference follows the latest frame.
    body(8, 5);
    vs_start();
    chk("alt1_lock", 32'(O_LOCKED), 32'd0);
    chk("alt1_vact", 32'(O_V_ACT), 32'd5);
    body(8, 4);
    vs_start();
    chk("alt2_lock", 32'(O_LOCKED), 32'd0);
    chk("alt2_vact", 32'(O_V_ACT), 32'd4);
    body(8, 5);
    vs_start();
    chk("alt3_lock", 32'(O_LOCKED), 32'd0);
    chk("alt3_vact", 32'(O_V_ACT), 32'd5);
    body(8, 5);
    vs_start();
    chk("relock5", 32'(O_LOCKED), 32'd1);
    chk("relock5_vact", 32'(O_V_ACT), 32'd5);

    // Mid-frame reset clears everything immediately.
    tick();
    I_VSYNC = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      I_DE       = 1'b1;
      I_PIX_DATA = pix(0, c);
      tick();
    end
    rst  = 1'b1;
    I_DE = 1'b0;
    #1;
    chk("arst_lock", 32'(O_LOCKED), 32'd0);
    chk("arst_hact", 32'(O_H_ACT), 32'd0);
    chk("arst_vact", 32'(O_V_ACT), 32'd0);
    chk("arst_de", 32'(O_DE), 32'd0);
    chk("arst_col", 32'(O_PIX_COL), 32'd0);
    chk("arst_pix", 32'(O_PIX_DATA), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    vs_start();
    chk("r_b1_lock", 32'(O_LOCKED), 32'd0);
    chk("r_b1_hact", 32'(O_H_ACT), 32'd0);
    body(8, 4);
    vs_start();
    chk("r_b2_lock", 32'(O_LOCKED), 32'd0);
    chk("r_b2_hact", 32'(O_H_ACT), 32'd8);
    body(8, 4);
    vs_start();
    chk("r_b3_lock", 32'(O_LOCKED), 32'd1);
    body(8, 4);

    // VSYNC edge on the same cycle as DE rise: that line is row 0.
    I_VSYNC    = 1'b1;
    I_DE       = 1'b1;
    I_PIX_DATA = pix(0, 0);
    tick();
    chk("co_sof", 32'(O_SOF), 32'd1);
    chk("co_row", 32'(O_PIX_ROW), 32'd0);
    chk("co_col", 32'(O_PIX_COL), 32'd0);
    chk("co_lock", 32'(O_LOCKED), 32'd1);
    for (int c = 1; c < 8; c++) begin
      I_PIX_DATA = pix(0, c);
      if (c == 2) I_VSYNC = 1'b0;
      tick();
      if (c == 1) chk("co_sof_once", 32'(O_SOF), 32'd0);
    end
    chk("co_col_last", 32'(O_PIX_COL), 32'd7);
    I_DE = 1'b0;
    tick();
    gap(0);
    for (int r = 1; r < 4; r++) begin
      line(r, 8);
      gap(r);
    end
    vs_start();
    chk("co_frame_lock", 32'(O_LOCKED), 32'd1);

    // Larger resolution acquires and locks.
    body(100, 20);
    vs_start();
    chk("w1_lock", 32'(O_LOCKED), 32'd0);
    chk("w1_hact", 32'(O_H_ACT), 32'd100);
    chk("w1_vact", 32'(O_V_ACT), 32'd20);
    body(100, 20);
    vs_start();
    chk("w2_lock", 32'(O_LOCKED), 32'd1);
    chk("w2_hact", 32'(O_H_ACT), 32'd100);

    // Over-long line saturates the column and spoils the frame.
    tick();
    I_VSYNC = 1'b0;
    tick();
    line(0, 4100);
    chk("ovf_unlock", 32'(O_LOCKED), 32'd0);
    gap(0);
    vs_start();
    chk("ovf_lock", 32'(O_LOCKED), 32'd0);
    chk("ovf_hact", 32'(O_H_ACT), 32'd100);
    chk("ovf_vact", 32'(O_V_ACT), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
